// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side port bundle of the MEM-stage SRAM controller.
// master = EX/MEM + MEM/WB side (drives the request), slave = the controller.
interface mem_stage_sram_ctrl_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [31:0] rdata_out;
    logic        ready;
    logic        freeze;

    modport master (
        output mem_r_en, mem_w_en, addr_in, wdata_in,
        input  rdata_out, ready, freeze
    );

    modport slave (
        input  mem_r_en, mem_w_en, addr_in, wdata_in,
        output rdata_out, ready, freeze
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: splits a 32-bit load/store into two 16-bit accesses
// (low half first) on an asynchronous SRAM and freezes the pipeline until the
// whole word has been transferred.
module mem_stage_sram_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_stage_sram_ctrl_if.slave bus,
    output logic [SRAM_AW-1:0]   sram_addr,
    inout  wire  [15:0]          sram_dq,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n
);

    localparam int unsigned   CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [31:0]        lat_waddr;
    logic [15:0]        lat_whi;     // high half of store data; low half goes straight to dq_out
    logic               lat_wr;
    logic [15:0]        rdata_lo;    // low half of a load, parked until the high half arrives
    logic [31:0]        rdata_q;
    logic [15:0]        dq_out;
    logic               dq_drv;
    logic               ce_q, oe_q, we_q;
    logic [SRAM_AW-1:0] addr_q;

    logic        req;
    logic        last;
    logic [31:0] waddr;

    assign req   = bus.mem_r_en | bus.mem_w_en;
    assign last  = (cnt == LAST);
    // Word index relative to the SRAM window; byte-lane bits fall out of the shift.
    assign waddr = (bus.addr_in - 32'(BASE_ADDR)) >> 2;

    assign bus.rdata_out = rdata_q;
    assign bus.freeze    = rst & (((state == IDLE) & req) | (state == LO) | (state == HI));
    assign bus.ready     = ~rst | ((state == IDLE) & ~req) | (state == DONE);

    // Bus pins are forced inactive while reset is held, not just after its edge.
    assign sram_ce_n = ce_q | ~rst;
    assign sram_oe_n = oe_q | ~rst;
    assign sram_we_n = we_q | ~rst;
    assign sram_addr = rst ? addr_q : '0;
    assign sram_dq   = (dq_drv & rst) ? dq_out : 16'bz;

    // Access FSM with registered SRAM strobes, address and write data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_waddr <= '0;
            lat_whi   <= '0;
            lat_wr    <= 1'b0;
            rdata_lo  <= '0;
            rdata_q   <= '0;
            dq_out    <= '0;
            dq_drv    <= 1'b0;
            ce_q      <= 1'b1;
            oe_q      <= 1'b1;
            we_q      <= 1'b1;
            addr_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state     <= LO;
                        cnt       <= '0;
                        lat_waddr <= waddr;
                        lat_whi   <= bus.wdata_in[31:16];
                        lat_wr    <= bus.mem_w_en;    // write wins when both enables are set
                        addr_q    <= SRAM_AW'({waddr, 1'b0});
                        dq_out    <= bus.wdata_in[15:0];
                        dq_drv    <= bus.mem_w_en;
                        ce_q      <= 1'b0;
                        we_q      <= ~bus.mem_w_en;
                        oe_q      <= bus.mem_w_en;
                    end
                end
                LO: begin
                    if (last) begin
                        state  <= HI;
                        cnt    <= '0;
                        addr_q <= SRAM_AW'({lat_waddr, 1'b1});
                        dq_out <= lat_whi;
                        if (!lat_wr) rdata_lo <= sram_dq;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HI: begin
                    if (last) begin
                        state  <= DONE;
                        cnt    <= '0;
                        dq_drv <= 1'b0;
                        ce_q   <= 1'b1;
                        oe_q   <= 1'b1;
                        we_q   <= 1'b1;
                        if (!lat_wr) rdata_q <= {sram_dq, rdata_lo};
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;    // DONE: pipeline advances this cycle
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a behavioural 2^18 x 16 SRAM.
module tb_mem_stage_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, oe_n, we_n;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl_if bus ();

    mem_stage_sram_ctrl #(
        .BASE_ADDR  (1024),
        .SRAM_AW    (18),
        .WAIT_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sram_addr(sram_addr),
        .sram_dq  (sram_dq),
        .sram_ce_n(ce_n),
        .sram_oe_n(oe_n),
        .sram_we_n(we_n)
    );

    // SRAM model: asynchronous read, write captured at the clock edge.
    logic [15:0] mem [0:(1<<18)-1];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'bz;
    always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr] <= sram_dq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full access starting from IDLE; ends in the DONE cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [17:0] lo_a,
                             input logic [31:0] exp_rd);
        int frz;
        tick();
        bus.mem_r_en = rd;
        bus.mem_w_en = wr;
        bus.addr_in  = a;
        bus.wdata_in = d;
        #1;
        frz = int'(bus.freeze);
        chk("idle_freeze", 32'(bus.freeze), 32'd1);
        chk("idle_ready",  32'(bus.ready),  32'd0);
        for (int h = 0; h < 2; h++) begin
            for (int c = 0; c < 2; c++) begin
                tick();
                // Scramble the request while frozen: controller must use latched values.
                bus.addr_in  = ~a;
                bus.wdata_in = ~d;
                #1;
                frz += int'(bus.freeze);
                chk("acc_ce_n", 32'(ce_n), 32'd0);
                chk("acc_addr", 32'(sram_addr), 32'(lo_a) + 32'(h));
                if (wr) begin
                    chk("wr_we_n", 32'(we_n), 32'd0);
                    chk("wr_oe_n", 32'(oe_n), 32'd1);
                    chk("wr_dq",   32'(sram_dq), (h == 0) ? 32'(d[15:0]) : 32'(d[31:16]));
                end else begin
                    chk("rd_oe_n", 32'(oe_n), 32'd0);
                    chk("rd_we_n", 32'(we_n), 32'd1);
                end
            end
        end
        tick();
        frz += int'(bus.freeze);
        chk("done_freeze", 32'(bus.freeze), 32'd0);
        chk("done_ready",  32'(bus.ready),  32'd1);
        chk("done_ce_n",   32'(ce_n), 32'd1);
        chk("done_we_n",   32'(we_n), 32'd1);
        chk("done_oe_n",   32'(oe_n), 32'd1);
        chk("done_rdata",  bus.rdata_out, exp_rd);
        chk("freeze_cycles", 32'(frz), 32'd5);
    endtask

    // Drop the request and check one quiet IDLE cycle.
    task automatic idle_chk(input logic [31:0] exp_rd);
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        tick();
        chk("idle_ce_n",   32'(ce_n), 32'd1);
        chk("idle_nofrz",  32'(bus.freeze), 32'd0);
        chk("idle_rdy",    32'(bus.ready), 32'd1);
        chk("idle_rdata",  bus.rdata_out, exp_rd);
    endtask

    // Directed sequence
    initial begin
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b1;
        bus.addr_in  = 32'd1024;
        bus.wdata_in = 32'h1111_2222;

        // 1: reset held with a pending write
        tick(); tick(); tick();
        chk("rst_freeze", 32'(bus.freeze), 32'd0);
        chk("rst_ready",  32'(bus.ready),  32'd1);
        chk("rst_we_n",   32'(we_n), 32'd1);
        chk("rst_ce_n",   32'(ce_n), 32'd1);
        chk("rst_oe_n",   32'(oe_n), 32'd1);
        chk("rst_addr",   32'(sram_addr), 32'd0);
        chk("rst_rdata",  bus.rdata_out, 32'd0);
        rst          = 1'b1;
        bus.mem_w_en = 1'b0;

        // 2: write 1024 <- DEADBEEF (halves at 0/1)
        do_access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 18'd0, 32'd0);
        idle_chk(32'd0);

        // 3: read it back, then held across idle
        do_access(1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 32'hDEAD_BEEF);
        idle_chk(32'hDEAD_BEEF);

        // 4: back-to-back write 1028 then read 1031 (same word, halves at 2/3)
        do_access(1'b0, 1'b1, 32'd1028, 32'h1234_5678, 18'd2, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 32'd1031, 32'd0, 18'd2, 32'h1234_5678);
        idle_chk(32'h1234_5678);

        // 5: reset during the first HI cycle of a write to 1036 (halves at 6/7)
        tick();
        bus.mem_w_en = 1'b1;
        bus.addr_in  = 32'd1036;
        bus.wdata_in = 32'hCAFE_F00D;
        #1;
        chk("ab_idle_freeze", 32'(bus.freeze), 32'd1);
        tick(); tick(); tick();
        chk("ab_hi_addr", 32'(sram_addr), 32'd7);
        chk("ab_hi_we_n", 32'(we_n), 32'd0);
        rst = 1'b0;
        #1;
        chk("ab_rst_freeze", 32'(bus.freeze), 32'd0);
        chk("ab_rst_ready",  32'(bus.ready), 32'd1);
        chk("ab_rst_we_n",   32'(we_n), 32'd1);
        tick();
        rst          = 1'b1;
        bus.mem_w_en = 1'b0;
        #1;
        chk("ab_post_freeze", 32'(bus.freeze), 32'd0);
        chk("ab_post_we_n",   32'(we_n), 32'd1);
        chk("ab_post_ce_n",   32'(ce_n), 32'd1);
        chk("ab_post_ready",  32'(bus.ready), 32'd1);
        chk("ab_post_rdata",  bus.rdata_out, 32'd0);
        do_access(1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 32'hDEAD_BEEF);
        idle_chk(32'hDEAD_BEEF);

        // 6: both enables set -> write to 1032 (halves at 4/5), rdata untouched
        do_access(1'b1, 1'b1, 32'd1032, 32'hA5A5_5A5A, 18'd4, 32'hDEAD_BEEF);
        idle_chk(32'hDEAD_BEEF);
        idle_chk(32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 32'd1032, 32'd0, 18'd4, 32'hA5A5_5A5A);
        idle_chk(32'hA5A5_5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
